// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// flushes, and EPC/Cause capture for reserved-instruction and overflow traps.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_reg_dst,
  input  logic              id_branch_eq,
  input  logic              id_branch_ne,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  input  logic              id_flush,
  input  logic              ex_flush,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  output logic              ex_reg_dst,
  output logic              ex_branch_eq,
  output logic              ex_branch_ne,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              exc_taken,
  output logic [DATA_W-1:0] epc,
  output logic [4:0]        cause
);

  localparam logic [4:0] CAUSE_RI = 5'd10;
  localparam logic [4:0] CAUSE_OV = 5'd12;
  localparam int         CTRL_W   = 10;
  localparam int         MRD_BIT  = 5;

  // Control bundle: {reg_dst, beq, bne, mem_to_reg, mem_read, mem_write, alu_src, reg_write, alu_op}
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] pc4_q, rs_data_q, rt_data_q, imm_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic              exc_d, exc_q;
  logic [DATA_W-1:0] epc_d, epc_q;
  logic [4:0]        cause_d, cause_q;
  logic              hazard;
  logic              bubble;

  function automatic logic [DATA_W-1:0] insn_addr(input logic [DATA_W-1:0] pc4);
    insn_addr = pc4 - DATA_W'(4);
  endfunction

  assign hazard = valid_q & ctrl_q[MRD_BIT] & (rt_q != '0) &
                  ((rt_q == id_rs) | (rt_q == id_rt));
  assign bubble = hazard | id_flush | ex_flush;

  always_comb begin
    ctrl_d  = '0;
    valid_d = 1'b0;
    if (!bubble) begin
      ctrl_d  = {id_reg_dst, id_branch_eq, id_branch_ne, id_mem_to_reg, id_mem_read,
                 id_mem_write, id_alu_src, id_reg_write, id_alu_op};
      valid_d = 1'b1;
    end
  end

  // Overflow wins over reserved-instruction: it belongs to the older instruction.
  always_comb begin
    exc_d   = 1'b0;
    epc_d   = epc_q;
    cause_d = cause_q;
    if (ex_flush && valid_q) begin
      exc_d   = 1'b1;
      epc_d   = insn_addr(pc4_q);
      cause_d = CAUSE_OV;
    end else if (id_flush) begin
      exc_d   = 1'b1;
      epc_d   = insn_addr(id_pc_plus4);
      cause_d = CAUSE_RI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      exc_q     <= 1'b0;
      epc_q     <= '0;
      cause_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      pc4_q     <= id_pc_plus4;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
    end
  end

  assign {ex_reg_dst, ex_branch_eq, ex_branch_ne, ex_mem_to_reg, ex_mem_read,
          ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op} = ctrl_q;
  assign ex_valid    = valid_q;
  assign ex_pc_plus4 = pc4_q;
  assign ex_rs_data  = rs_data_q;
  assign ex_rt_data  = rt_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign pc_write    = ~hazard;
  assign if_id_write = ~hazard;
  assign exc_taken   = exc_q;
  assign epc         = epc_q;
  assign cause       = cause_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for per-cycle behaviour plus a
// hand-written reset-during-stall sequence.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_reg_dst, id_branch_eq, id_branch_ne, id_mem_to_reg;
  logic        id_mem_read, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0]  id_alu_op;
  logic        id_flush, ex_flush;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_reg_dst, ex_branch_eq, ex_branch_ne, ex_mem_to_reg;
  logic        ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid, pc_write, if_id_write, exc_taken;
  logic [31:0] epc;
  logic [4:0]  cause;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_dst(id_reg_dst), .id_branch_eq(id_branch_eq), .id_branch_ne(id_branch_ne),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_flush(id_flush), .ex_flush(ex_flush), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_reg_dst(ex_reg_dst), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
    .exc_taken(exc_taken), .epc(epc), .cause(cause)
  );

  always #5 clk = ~clk;

  // ctrl = {reg_dst, beq, bne, mem_to_reg, mem_read, mem_write, alu_src, reg_write, alu_op}
  localparam logic [9:0] C_ADD = 10'b1000000110;
  localparam logic [9:0] C_LW  = 10'b0001101100;
  localparam logic [9:0] C_SW  = 10'b0000011000;

  typedef struct {
    logic [9:0]  ctrl;
    logic        idf, exf;
    logic [31:0] pc4, rsd, rtd;
    logic [4:0]  rs, rt, rd;
    logic        e_pcw, e_vld, e_exc;
    logic [31:0] e_epc;
    logic [4:0]  e_cause;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [9:0] ctrl, input logic idf, input logic exf,
                              input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic e_pcw, input logic e_vld, input logic e_exc,
                              input logic [31:0] e_epc, input logic [4:0] e_cause);
    vec_t v;
    v.ctrl = ctrl; v.idf = idf; v.exf = exf; v.pc4 = pc4;
    v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd;
    v.e_pcw = e_pcw; v.e_vld = e_vld; v.e_exc = e_exc;
    v.e_epc = e_epc; v.e_cause = e_cause;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {id_reg_dst, id_branch_eq, id_branch_ne, id_mem_to_reg, id_mem_read,
     id_mem_write, id_alu_src, id_reg_write, id_alu_op} = v.ctrl;
    id_flush = v.idf; ex_flush = v.exf; id_pc_plus4 = v.pc4;
    id_rs_data = v.rsd; id_rt_data = v.rtd; id_imm = v.rsd ^ 32'hFFFF0000;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
  endtask

  function automatic logic [9:0] ex_ctrl();
    return {ex_reg_dst, ex_branch_eq, ex_branch_ne, ex_mem_to_reg, ex_mem_read,
            ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op};
  endfunction

  task automatic apply(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v);
    n_vec++;
    #3;
    chk({tag, " pc_write"}, 32'(pc_write), 32'(v.e_pcw));
    chk({tag, " if_id_write"}, 32'(if_id_write), 32'(v.e_pcw));
    @(posedge clk);
    #1;
    chk({tag, " ex_valid"}, 32'(ex_valid), 32'(v.e_vld));
    chk({tag, " ctrl"}, 32'(ex_ctrl()), v.e_vld ? 32'(v.ctrl) : 32'd0);
    chk({tag, " exc_taken"}, 32'(exc_taken), 32'(v.e_exc));
    chk({tag, " epc"}, epc, v.e_epc);
    chk({tag, " cause"}, 32'(cause), 32'(v.e_cause));
    if (v.e_vld) begin
      chk({tag, " pc4"}, ex_pc_plus4, v.pc4);
      chk({tag, " rs_data"}, ex_rs_data, v.rsd);
      chk({tag, " rt_data"}, ex_rt_data, v.rtd);
      chk({tag, " imm"}, ex_imm, v.rsd ^ 32'hFFFF0000);
      chk({tag, " rs"}, 32'(ex_rs), 32'(v.rs));
      chk({tag, " rt"}, 32'(ex_rt), 32'(v.rt));
      chk({tag, " rd"}, 32'(ex_rd), 32'(v.rd));
    end
  endtask

  initial begin
    //           ctrl   idf  exf  pc4            rs rt  rd  rsd            rtd          pcw vld exc epc            cause
    tv[0]  = mk(C_ADD, 1'b0, 1'b0, 32'h00400004, 1, 2,  3,  32'h00000005, 32'h00000007, 1, 1, 0, 32'h0,        5'd0);
    tv[1]  = mk(C_LW,  1'b0, 1'b0, 32'h00400008, 4, 8,  0,  32'h00001000, 32'h0,        1, 1, 0, 32'h0,        5'd0);
    tv[2]  = mk(C_ADD, 1'b0, 1'b0, 32'h0040000C, 8, 9,  10, 32'h00000011, 32'h00000022, 0, 0, 0, 32'h0,        5'd0);
    tv[3]  = mk(C_ADD, 1'b0, 1'b0, 32'h0040000C, 8, 9,  10, 32'h00000011, 32'h00000022, 1, 1, 0, 32'h0,        5'd0);
    tv[4]  = mk(C_LW,  1'b0, 1'b0, 32'h00400010, 1, 0,  0,  32'h00002000, 32'h0,        1, 1, 0, 32'h0,        5'd0);
    tv[5]  = mk(C_ADD, 1'b0, 1'b0, 32'h00400014, 0, 3,  4,  32'h0,        32'h00000033, 1, 1, 0, 32'h0,        5'd0);
    tv[6]  = mk(C_LW,  1'b0, 1'b0, 32'h00400018, 2, 5,  0,  32'h00003000, 32'h0,        1, 1, 0, 32'h0,        5'd0);
    tv[7]  = mk(C_SW,  1'b0, 1'b0, 32'h0040001C, 6, 5,  0,  32'h00004000, 32'hABCD0000, 0, 0, 0, 32'h0,        5'd0);
    tv[8]  = mk(C_SW,  1'b0, 1'b0, 32'h0040001C, 6, 5,  0,  32'h00004000, 32'hABCD0000, 1, 1, 0, 32'h0,        5'd0);
    tv[9]  = mk(C_ADD, 1'b1, 1'b0, 32'h00400010, 1, 2,  3,  32'h1,        32'h2,        1, 0, 1, 32'h0040000C, 5'd10);
    tv[10] = mk(C_ADD, 1'b0, 1'b0, 32'h00400020, 1, 2,  3,  32'h7FFFFFFF, 32'h1,        1, 1, 0, 32'h0040000C, 5'd10);
    tv[11] = mk(C_ADD, 1'b1, 1'b1, 32'h00400028, 1, 2,  3,  32'h1,        32'h2,        1, 0, 1, 32'h0040001C, 5'd12);
    tv[12] = mk(C_ADD, 1'b0, 1'b0, 32'h00400030, 11, 12, 13, 32'h55555555, 32'hAAAAAAAA, 1, 1, 0, 32'h0040001C, 5'd12);
    tv[13] = mk(C_ADD, 1'b0, 1'b1, 32'h00400034, 1, 2,  3,  32'h1,        32'h2,        1, 0, 1, 32'h0040002C, 5'd12);
    tv[14] = mk(C_ADD, 1'b0, 1'b1, 32'h00400038, 1, 2,  3,  32'h1,        32'h2,        1, 0, 0, 32'h0040002C, 5'd12);
    tv[15] = mk(C_ADD, 1'b1, 1'b0, 32'h00000000, 1, 2,  3,  32'h1,        32'h2,        1, 0, 1, 32'hFFFFFFFC, 5'd10);
    tv[16] = mk(C_ADD, 1'b1, 1'b0, 32'h00400040, 1, 2,  3,  32'h1,        32'h2,        1, 0, 1, 32'h0040003C, 5'd10);
    tv[17] = mk(C_ADD, 1'b0, 1'b0, 32'h00400044, 14, 15, 16, 32'h12345678, 32'h9ABCDEF0, 1, 1, 0, 32'h0040003C, 5'd10);
    tv[18] = mk(C_LW,  1'b0, 1'b0, 32'h00400048, 1, 7,  0,  32'h00005000, 32'h0,        1, 1, 0, 32'h0040003C, 5'd10);
    tv[19] = mk(C_ADD, 1'b1, 1'b0, 32'h00400050, 7, 2,  3,  32'h1,        32'h2,        0, 0, 1, 32'h0040004C, 5'd10);
    tv[20] = mk(C_ADD, 1'b0, 1'b1, 32'h00400054, 1, 2,  3,  32'h1,        32'h2,        1, 0, 0, 32'h0040004C, 5'd10);

    rst_n = 1'b0;
    drive(mk(C_ADD, 1'b0, 1'b0, 32'h00400000, 1, 2, 3, 32'h9, 32'h9, 1, 1, 0, 32'h0, 5'd0));
    #2;
    n_vec++;
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset ctrl", 32'(ex_ctrl()), 32'd0);
    chk("reset rs_data", ex_rs_data, 32'd0);
    chk("reset exc_taken", 32'(exc_taken), 32'd0);
    chk("reset epc", epc, 32'd0);
    chk("reset cause", 32'(cause), 32'd0);
    chk("reset pc_write", 32'(pc_write), 32'd1);
    #5;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(i, tv[i]);

    // Reset asserted mid-stall must clear EX state and the hazard immediately.
    drive(mk(C_LW, 1'b0, 1'b0, 32'h00400060, 3, 8, 0, 32'h6000, 32'h0, 1, 1, 0, 32'h0, 5'd0));
    n_vec++;
    @(posedge clk);
    #1;
    chk("rs_pre ex_valid", 32'(ex_valid), 32'd1);
    drive(mk(C_ADD, 1'b0, 1'b0, 32'h00400064, 8, 9, 10, 32'h77, 32'h88, 1, 1, 0, 32'h0, 5'd0));
    #2;
    chk("rs_stall pc_write", 32'(pc_write), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rs_async pc_write", 32'(pc_write), 32'd1);
    chk("rs_async if_id_write", 32'(if_id_write), 32'd1);
    chk("rs_async ex_valid", 32'(ex_valid), 32'd0);
    chk("rs_async ex_mem_read", 32'(ex_mem_read), 32'd0);
    chk("rs_async ex_rt", 32'(ex_rt), 32'd0);
    chk("rs_async epc", epc, 32'd0);
    chk("rs_async cause", 32'(cause), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_post ex_valid", 32'(ex_valid), 32'd1);
    chk("rs_post ctrl", 32'(ex_ctrl()), 32'(C_ADD));
    chk("rs_post ex_rs", 32'(ex_rs), 32'd8);
    chk("rs_post ex_rs_data", ex_rs_data, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
